// File: rtl/cpu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package : cpu_pkg                                                  |
// | Shared CPU front-end constants and the fetch tuple type.           |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
package cpu_pkg;

  localparam int unsigned PC_WIDTH_DEF    = 32;
  localparam int unsigned INSTR_WIDTH_DEF = 32;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;
  localparam logic [31:0] NOP_INSTR    = 32'h00000013;  // addi x0, x0, 0

  typedef struct packed {
    logic [PC_WIDTH_DEF-1:0]    pc;
    logic [PC_WIDTH_DEF-1:0]    pc_plus4;
    logic [INSTR_WIDTH_DEF-1:0] instr;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_buffer_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : fetch_buffer_ctrl                                        |
// | Pointers, occupancy and handshake logic of the fetch buffer.       |
// | Reset beats flush; flush discards any push/pop in the same cycle.  |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module fetch_buffer_ctrl
  import cpu_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          push_valid_i,
  input  logic          pop_ready_i,
  output logic          push_ready_o,
  output logic          pop_valid_o,
  output logic          wr_en_o,
  output logic [PW-1:0] wr_ptr_o,
  output logic [PW-1:0] rd_ptr_o,
  output logic [CW-1:0] count_o
);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          push_fire;
  logic          pop_fire;

  // Handshakes and next-state; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    push_fire = push_valid_i && (count_q != CW'(DEPTH));
    pop_fire  = pop_ready_i  && (count_q != '0);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_fire) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_fire)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push_fire) - CW'(pop_fire);
    end
  end

  // State register with reset taking priority over everything else.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign push_ready_o = (count_q != CW'(DEPTH));
  assign pop_valid_o  = (count_q != '0);
  assign wr_en_o      = push_fire && !flush_i;
  assign wr_ptr_o     = wr_ptr_q;
  assign rd_ptr_o     = rd_ptr_q;
  assign count_o      = count_q;

endmodule
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : fetch_buffer                                             |
// | Fetch-to-decode decoupling queue of {pc, pc+4, instr} tuples with  |
// | flush on redirect. No bypass: one cycle push-to-pop latency.       |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module fetch_buffer
  import cpu_pkg::*;
#(
  parameter  int unsigned PC_WIDTH    = 32,
  parameter  int unsigned INSTR_WIDTH = 32,
  parameter  int unsigned DEPTH       = 2,
  localparam int unsigned CW          = $clog2(DEPTH + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   push_valid_i,
  output logic                   push_ready_o,
  input  logic [PC_WIDTH-1:0]    push_pc_i,
  input  logic [PC_WIDTH-1:0]    push_pc_plus4_i,
  input  logic [INSTR_WIDTH-1:0] push_instr_i,
  output logic                   pop_valid_o,
  input  logic                   pop_ready_i,
  output logic [PC_WIDTH-1:0]    pop_pc_o,
  output logic [PC_WIDTH-1:0]    pop_pc_plus4_o,
  output logic [INSTR_WIDTH-1:0] pop_instr_o,
  output logic [CW-1:0]          count_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic          wr_en;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic [PC_WIDTH-1:0]    pc_q    [DEPTH];
  logic [PC_WIDTH-1:0]    pc4_q   [DEPTH];
  logic [INSTR_WIDTH-1:0] instr_q [DEPTH];

  fetch_buffer_ctrl #(
    .DEPTH (DEPTH)
  ) u_ctrl (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (flush_i),
    .push_valid_i (push_valid_i),
    .pop_ready_i  (pop_ready_i),
    .push_ready_o (push_ready_o),
    .pop_valid_o  (pop_valid_o),
    .wr_en_o      (wr_en),
    .wr_ptr_o     (wr_ptr),
    .rd_ptr_o     (rd_ptr),
    .count_o      (count_o)
  );

  // Storage: zeroed on reset, written at the write pointer on an accepted push.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_q[i]    <= '0;
        pc4_q[i]   <= '0;
        instr_q[i] <= '0;
      end
    end else if (wr_en) begin
      pc_q[wr_ptr]    <= push_pc_i;
      pc4_q[wr_ptr]   <= push_pc_plus4_i;
      instr_q[wr_ptr] <= push_instr_i;
    end
  end

  // Head presentation; an empty queue shows a harmless NOP at pc 0.
  always_comb begin
    pop_pc_o       = '0;
    pop_pc_plus4_o = '0;
    pop_instr_o    = INSTR_WIDTH'(NOP_INSTR);
    if (pop_valid_o) begin
      pop_pc_o       = pc_q[rd_ptr];
      pop_pc_plus4_o = pc4_q[rd_ptr];
      pop_instr_o    = instr_q[rd_ptr];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : tb_fetch_buffer                                          |
// | Self-checking bench for fetch_buffer against a queue model.        |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module tb_fetch_buffer;
  import cpu_pkg::*;

  localparam int unsigned DEPTH = 2;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        push_valid_i = 1'b0;
  logic        push_ready_o;
  logic [31:0] push_pc_i = '0;
  logic [31:0] push_pc_plus4_i = '0;
  logic [31:0] push_instr_i = '0;
  logic        pop_valid_o;
  logic        pop_ready_i = 1'b0;
  logic [31:0] pop_pc_o;
  logic [31:0] pop_pc_plus4_o;
  logic [31:0] pop_instr_o;
  logic [1:0]  count_o;

  int checks   = 0;
  int failures = 0;

  fetch_entry_t model_q[$];

  fetch_buffer #(
    .PC_WIDTH    (32),
    .INSTR_WIDTH (32),
    .DEPTH       (DEPTH)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .flush_i         (flush_i),
    .push_valid_i    (push_valid_i),
    .push_ready_o    (push_ready_o),
    .push_pc_i       (push_pc_i),
    .push_pc_plus4_i (push_pc_plus4_i),
    .push_instr_i    (push_instr_i),
    .pop_valid_o     (pop_valid_o),
    .pop_ready_i     (pop_ready_i),
    .pop_pc_o        (pop_pc_o),
    .pop_pc_plus4_o  (pop_pc_plus4_o),
    .pop_instr_o     (pop_instr_o),
    .count_o         (count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, compare outputs with the model, clock, update the model.
  task automatic step(input logic rs, input logic fl, input logic pv, input logic [31:0] pc,
                      input logic [31:0] ins, input logic pr, input logic do_chk,
                      output logic accepted);
    logic push_acc, pop_acc;
    rst_i = rs; flush_i = fl; push_valid_i = pv; pop_ready_i = pr;
    push_pc_i = pc; push_pc_plus4_i = pc + 32'd4; push_instr_i = ins;
    #1;
    if (do_chk) begin
      chk("count", 32'(count_o), 32'(model_q.size()));
      chk("pop_valid", 32'(pop_valid_o), 32'(model_q.size() != 0));
      chk("push_ready", 32'(push_ready_o), 32'(model_q.size() != DEPTH));
      if (model_q.size() == 0) begin
        chk("pop_pc", pop_pc_o, 32'h0);
        chk("pop_pc4", pop_pc_plus4_o, 32'h0);
        chk("pop_instr", pop_instr_o, NOP_INSTR);
      end else begin
        chk("pop_pc", pop_pc_o, model_q[0].pc);
        chk("pop_pc4", pop_pc_plus4_o, model_q[0].pc_plus4);
        chk("pop_instr", pop_instr_o, model_q[0].instr);
      end
    end
    push_acc = pv && (model_q.size() < DEPTH);
    pop_acc  = pr && (model_q.size() > 0);
    accepted = push_acc && !fl && !rs;
    @(posedge clk_i);
    if (rs || fl) begin
      model_q.delete();
    end else begin
      if (pop_acc) void'(model_q.pop_front());
      if (push_acc) model_q.push_back('{pc: pc, pc_plus4: pc + 32'd4, instr: ins});
    end
    #1;
  endtask

  initial begin
    logic        acc;
    logic        hold_v;
    logic [31:0] hold_pc, hold_ins, next_pc;
    logic        rs, fl, pv, pr;
    logic [31:0] pc, ins;

    @(posedge clk_i); #1;

    // Reset for two cycles, then idle.
    step(1, 0, 0, 0, 0, 0, 0, acc);
    step(1, 0, 0, 0, 0, 0, 0, acc);
    model_q.delete();
    step(0, 0, 0, 0, 0, 0, 1, acc);
    step(0, 0, 0, 0, 0, 0, 1, acc);

    // Fill and drain, third push refused while full.
    step(0, 0, 1, RESET_VECTOR,          32'h00500093, 0, 1, acc);
    step(0, 0, 1, RESET_VECTOR + 32'd4,  32'h00A00113, 0, 1, acc);
    step(0, 0, 1, RESET_VECTOR + 32'd8,  32'h00000000, 0, 1, acc);
    chk("third_push_refused", 32'(acc), 32'd0);
    step(0, 0, 0, 0, 0, 1, 1, acc);
    step(0, 0, 0, 0, 0, 1, 1, acc);
    step(0, 0, 0, 0, 0, 1, 1, acc);

    // Streaming push+pop for ten cycles across pointer wrap.
    for (int i = 0; i < 10; i++)
      step(0, 0, 1, RESET_VECTOR + 32'(4 * i), 32'h1000_0000 + 32'(i), 1, 1, acc);
    step(0, 0, 0, 0, 0, 1, 1, acc);
    step(0, 0, 0, 0, 0, 0, 1, acc);

    // Full with pop: pop happens, push refused, then accepted next cycle.
    step(0, 0, 1, 32'h0000_1000, 32'hA1, 0, 1, acc);
    step(0, 0, 1, 32'h0000_1004, 32'hA2, 0, 1, acc);
    step(0, 0, 1, 32'h0000_1008, 32'hA3, 1, 1, acc);
    chk("full_pop_push_refused", 32'(acc), 32'd0);
    step(0, 0, 1, 32'h0000_1008, 32'hA3, 0, 1, acc);
    chk("push_after_full_pop", 32'(acc), 32'd1);
    step(0, 0, 0, 0, 0, 1, 1, acc);

    // Flush while full with push and pop attempted.
    step(0, 0, 1, 32'h0000_2000, 32'hB1, 0, 1, acc);
    step(0, 1, 1, 32'h0000_2004, 32'hB2, 1, 1, acc);
    step(0, 0, 1, 32'hBFC0_0100, 32'hB3, 0, 1, acc);
    step(0, 0, 0, 0, 0, 1, 1, acc);
    step(0, 0, 0, 0, 0, 0, 1, acc);

    // Reset mid-operation together with push and flush.
    step(0, 0, 1, 32'h0000_3000, 32'hC1, 0, 1, acc);
    step(0, 0, 1, 32'h0000_3004, 32'hC2, 0, 1, acc);
    step(1, 1, 1, 32'h0000_3008, 32'hC3, 1, 1, acc);
    step(0, 0, 1, RESET_VECTOR, 32'hC4, 0, 1, acc);
    step(0, 0, 0, 0, 0, 1, 1, acc);
    step(0, 0, 0, 0, 0, 0, 1, acc);

    // Randomized traffic; fetch holds a refused tuple stable.
    hold_v = 1'b0; hold_pc = '0; hold_ins = '0; next_pc = 32'h8000_0000;
    for (int i = 0; i < 400; i++) begin
      rs = ($urandom_range(0, 199) == 0);
      fl = ($urandom_range(0, 19) == 0);
      pr = ($urandom_range(0, 99) < 55);
      if (hold_v) begin
        pv = 1'b1; pc = hold_pc; ins = hold_ins;
      end else begin
        pv = ($urandom_range(0, 99) < 60);
        pc = next_pc; ins = $urandom;
        if (pv) next_pc = next_pc + 32'd4;
      end
      step(rs, fl, pv, pc, ins, pr, 1, acc);
      hold_v = pv && !acc && !rs && !fl;
      hold_pc = pc; hold_ins = ins;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Decoupling queue directly downstream of the program counter, between instruction fetch and decode.
- Captures {pc, pc_plus4, instr} tuples from fetch through a valid/ready handshake and presents them in order to decode.
- Lets fetch keep running while decode stalls.
- Drops all in-flight entries on a control-flow redirect (flush), so decode never sees wrong-path instructions.

Parameters:
- PC_WIDTH, 32, width of the pc and pc_plus4 fields.
- INSTR_WIDTH, 32, width of the instruction word.
- DEPTH, 2, number of entries; a power of two, at least 2.

Ports:
- clk_i  input  1  sole clock; all state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- flush_i  input  1  redirect (jump taken or jalr); empties the queue.
- push_valid_i  input  1  fetch presents a valid tuple.
- push_ready_o  output  1  queue can accept a tuple this cycle.
- push_pc_i  input  PC_WIDTH  pc of the fetched instruction.
- push_pc_plus4_i  input  PC_WIDTH  pc + 4 of the fetched instruction.
- push_instr_i  input  INSTR_WIDTH  fetched instruction word.
- pop_valid_o  output  1  head entry is valid.
- pop_ready_i  input  1  decode consumes the head this cycle.
- pop_pc_o  output  PC_WIDTH  head pc.
- pop_pc_plus4_o  output  PC_WIDTH  head pc + 4.
- pop_instr_o  output  INSTR_WIDTH  head instruction.
- count_o  output  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Clock and reset: one clock (clk_i); reset rst_i is synchronous, active-high.
- Reset: on any rising edge with rst_i=1, pointers and count_o go to 0.
  - pop_valid_o=0, push_ready_o=1.
  - Stored entries are zeroed.
  - Reset overrides flush, push and pop in the same cycle.
- Push: a transfer happens when push_valid_i && push_ready_o at the edge. The tuple is written at the write pointer; the write pointer increments modulo DEPTH.
- Pop: a transfer happens when pop_valid_o && pop_ready_i at the edge. The read pointer increments modulo DEPTH.
- push_ready_o = (count_o != DEPTH), combinational from registered count only. It does not depend on pop_ready_i (no same-cycle pass-through when full).
- pop_valid_o = (count_o != 0).
- No bypass: a tuple pushed at edge N is visible on pop_* after edge N, i.e. in the following cycle. Push-to-pop latency is 1 cycle.
- Pop outputs are driven combinationally from the head entry.
- When empty, outputs are forced: pop_pc_o=0, pop_pc_plus4_o=0, pop_instr_o=NOP (32'h00000013).
- Simultaneous push and pop (0<count<DEPTH): both occur and count_o is unchanged.
- Simultaneous push and pop when empty: only the push occurs, because pop_valid_o=0.
- Full (count_o=DEPTH): push is refused even if pop_ready_i=1. The pop still occurs, and push_ready_o rises next cycle.
- Flush: when flush_i=1 at an edge (and rst_i=0):
  - count_o, both pointers and all valid state go to 0.
  - Any push and any pop in that cycle are discarded; the decode handshake is not counted as a transfer.
  - Storage contents need not be cleared.
- Flush while empty: no effect beyond holding state.
- Wrap-around: pointers wrap from DEPTH-1 to 0; ordering is preserved across wrap.
- count_o never exceeds DEPTH and never underflows.
- Protocol requirement on fetch: push_* are held stable while push_valid_i && !push_ready_o. This is an assertion on the bench, not checked in RTL.

Decomposition:
- Shared package (cpu_pkg):
  - RESET_VECTOR = 32'hBFC00000
  - NOP_INSTR = 32'h00000013
  - typedef fetch_entry_t struct {pc, pc_plus4, instr}, sized by PC_WIDTH/INSTR_WIDTH defaults.
- One natural sub-module: fetch_buffer_ctrl, holding pointers, count, full/empty and flush/reset priority.
- The storage array and output mux stay in fetch_buffer.

Test Plan:
- Reset then idle: rst_i=1 for 2 cycles -> count_o=0, pop_valid_o=0, push_ready_o=1, pop_instr_o=32'h00000013, pop_pc_o=0.
- Fill and drain: push pc=BFC00000, then BFC00004 (instr 0x00500093, 0x00A00113), pop_ready_i=0.
  - count_o goes 1 then 2, and push_ready_o=0.
  - Third push of BFC00008 is refused.
  - Then pop_ready_i=1 -> pops BFC00000, then BFC00004 in order, with pop_pc_plus4_o=BFC00004, BFC00008.
- Streaming: push and pop every cycle for 10 cycles starting at BFC00000 -> count_o holds 1 after the first cycle. Outputs are pc BFC00000..BFC00024 in order with 1-cycle latency, exercising wrap-around.
- Full with pop: count_o=2, push_valid_i=1, pop_ready_i=1 -> one pop, push refused, count_o=1. Next cycle push_ready_o=1 and the push is accepted.
- Flush: count_o=2, flush_i=1 with push_valid_i=1 and pop_ready_i=1 -> next cycle count_o=0, pop_valid_o=0, pushed tuple absent. The next push, pc=BFC00100, is the first popped.
- Reset mid-operation: count_o=2, rst_i=1 together with push and flush -> count_o=0, push_ready_o=1. A subsequent push/pop behaves as after a clean reset.
